// File: rtl/pc_npc_sequencer_if.sv
// Handshake bundle between decode/branch resolution (master) and the PC/nPC sequencer (slave).
interface pc_npc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             ctl_valid;
  logic [1:0]       ctl_type;
  logic             cond_true;
  logic             annul_bit;
  logic [WIDTH-1:0] ta;
  logic [WIDTH-1:0] alu_out;
  logic             trap_req;
  logic [WIDTH-1:0] trap_vec;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic             pc_le;
  logic             npc_le;
  logic [1:0]       pc_mux;
  logic             squash;
  logic [1:0]       state;

  modport master (
    output stall, ctl_valid, ctl_type, cond_true, annul_bit, ta, alu_out, trap_req, trap_vec,
    input  pc, npc, pc_le, npc_le, pc_mux, squash, state
  );

  modport slave (
    input  stall, ctl_valid, ctl_type, cond_true, annul_bit, ta, alu_out, trap_req, trap_vec,
    output pc, npc, pc_le, npc_le, pc_mux, squash, state
  );
endinterface

// File: rtl/pc_npc_sequencer.sv
// Architectural PC/nPC sequencer with SPARC delayed-branch, annul and trap redirect handling.
module pc_npc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      INC      = 4
) (
  input  logic                clk,
  input  logic                clr,
  pc_npc_sequencer_if.slave   bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  localparam logic [1:0] CTL_SEQ  = 2'b00;
  localparam logic [1:0] CTL_BICC = 2'b01;
  localparam logic [1:0] CTL_UNC  = 2'b10;
  localparam logic [1:0] CTL_JMPL = 2'b11;

  localparam logic [1:0] MUX_SEQ  = 2'b00;
  localparam logic [1:0] MUX_TA   = 2'b01;
  localparam logic [1:0] MUX_ALU  = 2'b10;
  localparam logic [1:0] MUX_TRAP = 2'b11;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_TRAP  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic             squash_q, squash_d;
  logic             load_en;
  logic [1:0]       mux_sel;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + INC_W;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    squash_d = squash_q;
    load_en  = 1'b0;
    mux_sel  = MUX_SEQ;

    unique case (state_q)
      ST_RESET: state_d = ST_RUN;

      ST_RUN, ST_TRAP: begin
        if (bus.trap_req) begin
          // Trap wins over stall and any pending control transfer.
          load_en  = 1'b1;
          mux_sel  = MUX_TRAP;
          pc_d     = bus.trap_vec;
          npc_d    = bus.trap_vec + INC_W;
          squash_d = 1'b0;
          state_d  = ST_TRAP;
        end else if (state_q == ST_TRAP) begin
          state_d = ST_RUN;
        end else if (!bus.stall) begin
          load_en  = 1'b1;
          pc_d     = npc_q;
          npc_d    = npc_q + INC_W;
          squash_d = 1'b0;
          // An annulled instruction at pc never redirects.
          if (bus.ctl_valid && !squash_q) begin
            unique case (bus.ctl_type)
              CTL_SEQ: ;
              CTL_BICC: begin
                if (bus.cond_true) begin
                  mux_sel = MUX_TA;
                  npc_d   = bus.ta;
                end else begin
                  squash_d = bus.annul_bit;
                end
              end
              CTL_UNC: begin
                mux_sel  = MUX_TA;
                npc_d    = bus.ta;
                squash_d = bus.annul_bit;
              end
              CTL_JMPL: begin
                mux_sel = MUX_ALU;
                npc_d   = bus.alu_out;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

  assign bus.pc     = pc_q;
  assign bus.npc    = npc_q;
  assign bus.squash = squash_q;
  assign bus.state  = state_q;
  assign bus.pc_le  = load_en;
  assign bus.npc_le = load_en;
  assign bus.pc_mux = mux_sel;

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Controller that owns the architectural PC/nPC pair and sequences it with SPARC delayed-branch semantics.
- Each cycle it selects the nPC source (sequential, branch target, jmpl ALU result or trap vector), drives the register load enables, and flags annulled delay-slot instructions.
- Sits between the decode/branch-resolution logic and the fetch stage; instruction memory is addressed from pc.

Parameters:
- WIDTH, 32, address width.
- RESET_PC, 0, PC value loaded at reset.
- INC, 4, sequential increment.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset. Asynchronous, active-low.
- stall  in  1  hazard hold. 1 freezes pc, npc, squash and state.
- ctl_valid  in  1  a control-transfer instruction at pc resolved this cycle.
- ctl_type  in  2  00 sequential, 01 conditional Bicc, 10 unconditional (ba/call), 11 jmpl.
- cond_true  in  1  branch condition result, used for type 01 only.
- annul_bit  in  1  instruction's a-bit.
- ta  in  WIDTH  branch/call target address.
- alu_out  in  WIDTH  jmpl computed target.
- trap_req  in  1  trap/interrupt request.
- trap_vec  in  WIDTH  trap handler address.
- pc  out  WIDTH  current PC.
- npc  out  WIDTH  next PC.
- pc_le  out  1  pc register load enable for this cycle.
- npc_le  out  1  npc register load enable for this cycle.
- pc_mux  out  2  npc source select: 00 npc+INC, 01 ta, 10 alu_out, 11 trap_vec.
- squash  out  1  instruction at pc is annulled; downstream treats it as a nop.
- state  out  2  00 RESET, 01 RUN, 10 TRAP (debug/verification).

Behaviour:
- Reset (clr=0, any time, asynchronous): pc=RESET_PC, npc=RESET_PC+INC, squash=0, state=RESET. Combinational outputs are pc_le=0, npc_le=0, pc_mux=00. Reset in mid-branch discards all pending redirects.
- RESET: first rising edge after clr deasserts moves to RUN with no pc/npc change, so RESET_PC is fetched for one full cycle.
- RUN, advance = !stall || trap_req. pc_le = npc_le = advance.
  - Trap (trap_req=1) has the highest priority and overrides stall and ctl_valid: pc<=trap_vec, npc<=trap_vec+INC, squash<=0, state<=TRAP, pc_mux=11.
  - Otherwise, if stall=1: hold everything. ctl inputs are ignored and must be held by the requester.
  - Otherwise pc<=npc always. Then:
    - ctl_valid=0, or ctl_type=00, or squash=1 (an annulled instruction never redirects): npc<=npc+INC, pc_mux=00, squash<=0.
    - type 01, cond_true=1: npc<=ta, pc_mux=01, squash<=0. The delay slot executes even if annul_bit=1.
    - type 01, cond_true=0: npc<=npc+INC, pc_mux=00, squash<=annul_bit.
    - type 10: npc<=ta, pc_mux=01, squash<=annul_bit.
    - type 11: npc<=alu_out, pc_mux=10, squash<=0. annul_bit is ignored.
- TRAP: one cycle, handler fetch. Next edge moves to RUN with no advance. pc_le=npc_le=0 unless trap_req is reasserted, in which case the trap is re-entered with the new vector.
- Arithmetic: npc+INC is modulo 2^WIDTH (0xFFFFFFFC+4 = 0x00000000). ta, alu_out and trap_vec pass through unmodified; alignment checking is out of scope.
- pc_mux, pc_le and npc_le are combinational from the current state and inputs. pc, npc, squash and state are registered.
- squash clears on the next advance only; it is held through stalls.

Test Plan:
- Reset/sequential: clr=0 for 2 cycles, then release, no ctl. pc/npc = 0/4, held for 1 cycle (RESET), then 4/8, 8/12, 12/16 on successive edges; squash=0 throughout.
- Taken Bicc + stall: at pc=8, ctl_valid=1, type=01, cond_true=1, annul_bit=1, ta=0x100, with stall=1 for 2 cycles, then 0. pc=8, npc=12 held during the stall. Then pc=12, npc=0x100, squash=0. Next edge pc=0x100, npc=0x104.
- Untaken annulled Bicc: at pc=8, type=01, cond_true=0, annul_bit=1. pc=12, npc=16, squash=1. A type 10 request issued while squash=1 is ignored: next pc=16, npc=20, squash=0.
- ba,a and jmpl: at pc=8, type=10, annul_bit=1, ta=0x40 gives pc=12 (squash=1), npc=0x40. Separately, type=11, alu_out=0x200 gives npc=0x200, pc_mux=10.
- Trap priority: trap_req=1 with stall=1, ctl_valid=1, trap_vec=0x80. pc=0x80, npc=0x84, state=TRAP, squash=0. Next edge state=RUN with pc unchanged.
- Wrap and async reset: npc=0xFFFFFFFC advancing gives npc=0x00000000. Asserting clr between clock edges immediately gives pc=0, npc=4, squash=0.
